rsa_job_arbiter: RTL and testbench

- Shares the single rsa_unit between N_REQ requesters (e.g. SPI host, GPIO-triggered sequencer, self-test).
- Per job: round-robin grant, registered operand capture, held-reset clear of the unit, run with timeout watchdog, result return on a valid/ready handshake.
- Replaces direct start/stop wiring between the wrappers and the RSA enable logic; sits between the request sources and rsa_unit.

---
 rtl/rsa_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rsa_job_arbiter.sv | 139 +++++++++++++
 tb/tb_rsa_job_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job arbiter and its round-robin grant logic.
package rsa_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} rsa_state_e;

   localparam int unsigned OWNER_W     = 2;
   localparam int unsigned TMO_DEFAULT = 1000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
   import rsa_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]       req_i,
   input  logic [OWNER_W-1:0] ptr_i,
   output logic [N-1:0]       gnt_o,
   output logic [OWNER_W-1:0] idx_o
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   cand;
   logic           found;

   assign req_dbl = {req_i, req_i};

   always_comb begin
      // Rotate so bit 0 is the requester at ptr_i, then scan upwards.
      cand  = N'(req_dbl >> ptr_i);
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int unsigned off = 0; off < N; off++) begin
         if (!found && cand[0]) begin
            found = 1'b1;
            idx_o = OWNER_W'((32'(ptr_i) + off) % N);
            gnt_o = N'(1) << idx_o;
         end
         cand = cand >> 1;
      end
   end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one rsa_unit between N_REQ requesters: round-robin grant, operand capture,
// held-reset clear, watchdog-bounded run and a valid/ready result return.
module rsa_job_arbiter
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_REQ = 2,
   parameter int unsigned TMO_W = 16
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   ena,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_p,
   input  logic [N_REQ*WIDTH-1:0] req_e,
   input  logic [N_REQ*WIDTH-1:0] req_m,
   input  logic [N_REQ*WIDTH-1:0] req_const,
   input  logic [N_REQ-1:0]       abort,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_c,
   output logic                   rsp_err,
   input  logic [TMO_W-1:0]       timeout_cfg,
   output logic                   busy,
   output logic [OWNER_W-1:0]     owner,
   output logic                   irq,
   output logic                   en_rsa,
   output logic                   rst_rsa,
   output logic [WIDTH-1:0]       rsa_p,
   output logic [WIDTH-1:0]       rsa_e,
   output logic [WIDTH-1:0]       rsa_m,
   output logic [WIDTH-1:0]       rsa_const,
   input  logic                   rsa_eoc,
   input  logic [WIDTH-1:0]       rsa_c
);

   rsa_state_e         state_q;
   logic [OWNER_W-1:0] rr_ptr_q, owner_q;
   logic [N_REQ-1:0]   owner_oh_q;
   logic [TMO_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   rsa_p_q, rsa_e_q, rsa_m_q, rsa_const_q, rsp_c_q;
   logic               rsp_err_q, irq_q;

   logic [N_REQ-1:0]   gnt;
   logic [OWNER_W-1:0] gnt_idx;
   logic               grant_en, take, own_abort, own_ready, tmo_hit;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign grant_en  = rstb && ena && (state_q == StIdle);
   assign req_ready = grant_en ? gnt : '0;
   assign take      = grant_en && (|req_valid);
   assign own_abort = |(abort & owner_oh_q);
   assign own_ready = |(rsp_ready & owner_oh_q);
   assign tmo_hit   = ena && (timeout_cfg != '0) && (cnt_q == timeout_cfg - TMO_W'(1));

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         owner_oh_q  <= '0;
         cnt_q       <= '0;
         rsa_p_q     <= '0;
         rsa_e_q     <= '0;
         rsa_m_q     <= '0;
         rsa_const_q <= '0;
         rsp_c_q     <= '0;
         rsp_err_q   <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         irq_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (take) begin
                  rsa_p_q     <= WIDTH'(req_p >> (gnt_idx * WIDTH));
                  rsa_e_q     <= WIDTH'(req_e >> (gnt_idx * WIDTH));
                  rsa_m_q     <= WIDTH'(req_m >> (gnt_idx * WIDTH));
                  rsa_const_q <= WIDTH'(req_const >> (gnt_idx * WIDTH));
                  owner_q     <= gnt_idx;
                  owner_oh_q  <= gnt;
                  rr_ptr_q    <= (gnt_idx == OWNER_W'(N_REQ - 1)) ? '0 : gnt_idx + OWNER_W'(1);
                  state_q     <= StLoad;
               end
            end
            StLoad: begin
               cnt_q   <= '0;
               state_q <= StRun;
            end
            StRun: begin
               // Abort beats eoc, eoc beats the watchdog.
               if (own_abort) begin
                  state_q <= StIdle;
               end else if (rsa_eoc) begin
                  rsp_c_q   <= rsa_c;
                  rsp_err_q <= 1'b0;
                  irq_q     <= 1'b1;
                  state_q   <= StResp;
               end else if (tmo_hit) begin
                  rsp_c_q   <= '0;
                  rsp_err_q <= 1'b1;
                  irq_q     <= 1'b1;
                  state_q   <= StResp;
               end else if (ena) begin
                  cnt_q <= cnt_q + TMO_W'(1);
               end
            end
            StResp: begin
               if (own_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy      = (state_q != StIdle);
   assign en_rsa    = (state_q == StRun) && ena;
   assign rst_rsa   = (state_q == StRun) || (state_q == StResp);
   assign rsp_valid = (state_q == StResp) ? owner_oh_q : '0;
   assign rsp_c     = rsp_c_q;
   assign rsp_err   = rsp_err_q;
   assign owner     = owner_q;
   assign irq       = irq_q;
   assign rsa_p     = rsa_p_q;
   assign rsa_e     = rsa_e_q;
   assign rsa_m     = rsa_m_q;
   assign rsa_const = rsa_const_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Randomized bench for rsa_job_arbiter with a behavioural rsa_unit and job-level timing model.
module tb_rsa_job_arbiter;
   import rsa_pkg::*;

   localparam int N        = 2;
   localparam int W        = 8;
   localparam int TW       = 16;
   localparam int GapStart = 4;

   logic             clk, rstb, ena;
   logic [N-1:0]     req_valid, req_ready, abort, rsp_valid, rsp_ready;
   logic [N*W-1:0]   req_p, req_e, req_m, req_const;
   logic [W-1:0]     rsp_c, rsa_p, rsa_e, rsa_m, rsa_const, rsa_c;
   logic             rsp_err, busy, irq, en_rsa, rst_rsa, rsa_eoc;
   logic [TW-1:0]    timeout_cfg;
   logic [OWNER_W-1:0] owner;

   logic [W-1:0]     op_p[N], op_e[N], op_m[N], op_k[N];
   int               n_checks, n_fail, ptr_m;
   int unsigned      d_cur, ucnt;

   rsa_job_arbiter #(
      .WIDTH (W),
      .N_REQ (N),
      .TMO_W (TW)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .ena         (ena),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_p       (req_p),
      .req_e       (req_e),
      .req_m       (req_m),
      .req_const   (req_const),
      .abort       (abort),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_c       (rsp_c),
      .rsp_err     (rsp_err),
      .timeout_cfg (timeout_cfg),
      .busy        (busy),
      .owner       (owner),
      .irq         (irq),
      .en_rsa      (en_rsa),
      .rst_rsa     (rst_rsa),
      .rsa_p       (rsa_p),
      .rsa_e       (rsa_e),
      .rsa_m       (rsa_m),
      .rsa_const   (rsa_const),
      .rsa_eoc     (rsa_eoc),
      .rsa_c       (rsa_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                           input logic [W-1:0] p);
      int unsigned r;
      if (p == 0) return '0;
      r = 1 % int'(p);
      for (int i = 0; i < int'(e); i++) r = (r * int'(m)) % int'(p);
      return W'(r);
   endfunction

   // Behavioural unit: counts enabled cycles out of reset, eoc once D have elapsed.
   always @(posedge clk) begin
      if (!rst_rsa) ucnt <= 0;
      else if (en_rsa && ucnt < d_cur) ucnt <= ucnt + 1;
   end
   assign rsa_eoc = rst_rsa && (ucnt >= d_cur);
   assign rsa_c   = modexp(rsa_m, rsa_e, rsa_p);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] m, input int ptr);
      logic [N-1:0] t;
      for (int k = 0; k < N; k++) begin
         t = m >> ((ptr + k) % N);
         if (t[0]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   // Cycle (counted from the grant) holding the j-th ena-high RUN cycle; RUN starts at 2.
   function automatic int n_of(input int j, input int gap);
      return (j <= GapStart - 2) ? 1 + j : 1 + j + gap;
   endfunction

   // kind: 0 normal, 1 owner abort on the eoc cycle, 2 non-owner abort, 3 reset mid-RUN
   task automatic serve_one(input logic [N-1:0] mask, input bit rnd, input int d, input int tmo,
                            input int gap, input int rdy_delay, input int kind);
      int g, n_eoc, n_tmo, n_end, resp_n;
      bit exp_err;
      logic [W-1:0] exp_c;
      logic [N-1:0] g_oh, other;
      if (rnd) begin
         for (int i = 0; i < N; i++) begin
            op_p[i] = W'($urandom_range(255, 2));
            op_e[i] = W'($urandom_range(255, 0));
            op_m[i] = W'($urandom);
            op_k[i] = W'($urandom);
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         req_p     = {req_p[N*W-W-1:0], op_p[i]};
         req_e     = {req_e[N*W-W-1:0], op_e[i]};
         req_m     = {req_m[N*W-W-1:0], op_m[i]};
         req_const = {req_const[N*W-W-1:0], op_k[i]};
      end
      req_valid = mask; ena = 1'b1; abort = '0; rsp_ready = '0;
      d_cur = d; timeout_cfg = TW'(tmo);
      #1;
      g     = pick(mask, ptr_m);
      g_oh  = N'(1) << g;
      other = ~g_oh;
      check_eq("grant", req_ready, g_oh);
      n_eoc   = n_of(d, gap) + 1;
      n_tmo   = n_of(tmo, gap);
      exp_err = (tmo != 0) && (n_tmo < n_eoc);
      n_end   = exp_err ? n_tmo : n_eoc;
      resp_n  = n_end + 1;
      exp_c   = exp_err ? '0 : modexp(op_m[g], op_e[g], op_p[g]);
      ptr_m   = (g + 1) % N;

      @(negedge clk); #1;
      check_eq("load_owner", owner, g);
      check_eq("load_ctl", {busy, rst_rsa, en_rsa, req_ready}, {3'b100, {N{1'b0}}});
      check_eq("load_operands", {rsa_p, rsa_e, rsa_m, rsa_const},
               {op_p[g], op_e[g], op_m[g], op_k[g]});

      for (int n = 2; n <= resp_n; n++) begin
         @(negedge clk);
         ena   = !(gap > 0 && n >= GapStart && n < GapStart + gap);
         abort = (kind == 2) ? other : ((kind == 1 && n == n_end) ? g_oh : '0);
         if (kind == 3 && n == 5) rstb = 1'b0;
         #1;
         if (kind == 3 && n == 6) begin
            check_eq("midreset_outputs", {req_ready, rsp_valid, rsp_c, rsp_err, busy, owner, irq,
                     en_rsa, rst_rsa, rsa_p, rsa_e, rsa_m, rsa_const}, '0);
            rstb = 1'b1; ptr_m = 0; abort = '0; ena = 1'b1;
            return;
         end
         if (kind == 1 && n == n_end + 1) begin
            check_eq("abort_idle", {busy, rsp_valid, irq, rst_rsa, en_rsa}, '0);
            abort = '0;
            return;
         end
         check_eq("rsp_valid", rsp_valid, (n == resp_n) ? g_oh : '0);
         check_eq("irq", irq, n == resp_n);
         check_eq("no_grant_busy", req_ready, '0);
         check_eq("en_rsa", en_rsa, (n <= n_end) ? ena : 1'b0);
      end
      check_eq("rsp_c", rsp_c, exp_c);
      check_eq("rsp_err", rsp_err, exp_err);

      rsp_ready = (rdy_delay == 0) ? g_oh : (N'($urandom) & other);
      abort     = N'($urandom);
      for (int k = 1; k <= rdy_delay; k++) begin
         @(negedge clk);
         rsp_ready = (k == rdy_delay) ? g_oh : (N'($urandom) & other);
         abort     = N'($urandom);
         #1;
         check_eq("hold_valid", rsp_valid, g_oh);
         check_eq("hold_result", {rsp_c, rsp_err}, {exp_c, exp_err});
         check_eq("hold_no_grant", {req_ready, irq}, '0);
      end
      @(negedge clk);
      rsp_ready = '0; abort = '0;
      #1;
      check_eq("done_idle", {busy, rsp_valid}, '0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0; ptr_m = 0; d_cur = 0;
      rstb = 1'b0; ena = 1'b0; req_valid = '0; abort = '0; rsp_ready = '0;
      req_p = '0; req_e = '0; req_m = '0; req_const = '0; timeout_cfg = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_outputs", {req_ready, rsp_valid, rsp_c, rsp_err, busy, owner, irq, en_rsa,
               rst_rsa, rsa_p, rsa_e, rsa_m, rsa_const}, '0);
      rstb = 1'b1;

      op_p[0] = 8'd13; op_e[0] = 8'd3; op_m[0] = 8'd5; op_k[0] = 8'h5a;
      op_p[1] = 8'd97; op_e[1] = 8'd7; op_m[1] = 8'd11; op_k[1] = 8'ha5;
      serve_one(2'b01, 1'b0, 10, TMO_DEFAULT, 0, 2, 0);

      // Pointer now sits at 1, so contention starts with requester 1.
      repeat (6) serve_one(2'b11, 1'b1, $urandom_range(12, 0), TMO_DEFAULT, 0,
                           $urandom_range(3, 0), 0);

      serve_one(2'b01, 1'b1, 50, 20, 0, 1, 0);
      serve_one(2'b10, 1'b1, 300, 0, 0, 0, 0);
      serve_one(2'b01, 1'b1, 6, 7, 0, 0, 0);
      serve_one(2'b10, 1'b1, 0, 1, 0, 0, 0);
      serve_one(2'b10, 1'b1, 8, 0, 0, 0, 1);
      serve_one(2'b11, 1'b1, 8, 0, 0, 0, 1);
      serve_one(2'b01, 1'b1, 9, TMO_DEFAULT, 0, 1, 2);
      serve_one(2'b11, 1'b1, 9, TMO_DEFAULT, 0, 1, 2);
      serve_one(2'b11, 1'b1, 4, TMO_DEFAULT, 0, 15, 0);
      serve_one(2'b01, 1'b1, 10, TMO_DEFAULT, 5, 0, 0);
      serve_one(2'b10, 1'b1, 50, 20, 5, 0, 0);
      serve_one(2'b11, 1'b1, 20, TMO_DEFAULT, 0, 0, 3);
      serve_one(2'b11, 1'b1, 5, TMO_DEFAULT, 0, 1, 0);

      repeat (12) begin
         int t_sel, tmo;
         logic [N-1:0] m;
         m = N'($urandom_range(3, 1));
         t_sel = $urandom_range(2, 0);
         tmo = (t_sel == 0) ? 0 : ((t_sel == 1) ? TMO_DEFAULT : $urandom_range(15, 1));
         serve_one(m, 1'b1, $urandom_range(12, 0), tmo, 0, $urandom_range(4, 0), 0);
      end

      req_valid = '0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
